wddl_eval_ctrl: RTL and testbench

- Precharge/evaluate sequencer for a dual-rail WDDL combinational datapath, such as the wddl_xorN trees.
- Accepts single-rail operands on a valid/ready handshake and drives them onto the datapath inputs as complementary rails for a fixed evaluate window.
- Samples the datapath output rails at the end of that window, then forces all rails to 0 (precharge) for a fixed window.
- Checks rail integrity in both phases: complementary during evaluate, all-zero during precharge. Results leave on a valid/ready handshake.

---
 rtl/wddl_pkg.sv | 43 ++++
 rtl/wddl_rail_check.sv | 21 ++
 rtl/wddl_eval_ctrl.sv | 144 ++++++++++++++
 tb/tb_wddl_eval_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wddl_pkg.sv
// Shared types and rail helpers for WDDL precharge/evaluate control blocks.
// Helpers operate on a fixed maximum width; callers zero-extend narrower rails.
package wddl_pkg;

  localparam int unsigned WDDL_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    PRE,
    HOLD
  } wddl_state_e;

  typedef logic [WDDL_MAX_W-1:0] wddl_word_t;

  typedef struct packed {
    wddl_word_t p;
    wddl_word_t n;
  } wddl_rail_t;

  function automatic wddl_rail_t wddl_encode(input wddl_word_t d);
    wddl_rail_t r;
    r.p = d;
    r.n = ~d;
    return r;
  endfunction

  function automatic wddl_word_t wddl_width_mask(input int unsigned w);
    if (w >= WDDL_MAX_W) return '1;
    return (wddl_word_t'(1) << w) - wddl_word_t'(1);
  endfunction

  // Bits above w are padding (both rails zero) and must not count as a fault.
  function automatic logic wddl_is_comp(input wddl_word_t p, input wddl_word_t n,
                                        input int unsigned w);
    return &((p ^ n) | ~wddl_width_mask(w));
  endfunction

  function automatic logic wddl_is_zero(input wddl_word_t p, input wddl_word_t n);
    return ~|(p | n);
  endfunction

endpackage

// File: rtl/wddl_rail_check.sv
// Combinational integrity check of a dual-rail bus: complementary and all-zero flags.
module wddl_rail_check
  import wddl_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic [OUT_WIDTH-1:0] p_rail,
  input  logic [OUT_WIDTH-1:0] n_rail,
  output logic                 comp_ok,
  output logic                 zero_ok
);

  wddl_word_t p_ext;
  wddl_word_t n_ext;

  assign p_ext   = WDDL_MAX_W'(p_rail);
  assign n_ext   = WDDL_MAX_W'(n_rail);
  assign comp_ok = wddl_is_comp(p_ext, n_ext, OUT_WIDTH);
  assign zero_ok = wddl_is_zero(p_ext, n_ext);

endmodule

// File: rtl/wddl_eval_ctrl.sv
// Precharge/evaluate sequencer for a dual-rail WDDL datapath with rail
// integrity checking and valid/ready operand/result handshakes.
module wddl_eval_ctrl
  import wddl_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned EVAL_CYCLES = 2,
  parameter int unsigned PRE_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic [IN_WIDTH-1:0]  dp_p_out,
  output logic [IN_WIDTH-1:0]  dp_n_out,
  input  logic [OUT_WIDTH-1:0] dp_p_in,
  input  logic [OUT_WIDTH-1:0] dp_n_in,
  output logic                 precharge,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_err,
  output logic                 pre_err
);

  localparam int unsigned CNT_MAX = (EVAL_CYCLES > PRE_CYCLES) ? EVAL_CYCLES : PRE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYCLES - 1);
  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYCLES - 1);

  wddl_state_e          state_q, state_d;
  logic [CW-1:0]        eval_cnt_q, eval_cnt_d;
  logic [CW-1:0]        pre_cnt_q, pre_cnt_d;
  logic [IN_WIDTH-1:0]  dp_p_d, dp_n_d;
  logic                 precharge_d;
  logic                 out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_d;
  logic                 out_err_d;
  logic                 pre_err_d;

  wddl_rail_t rail_enc;
  logic       unused_enc;
  logic       comp_ok;
  logic       zero_ok;

  assign rail_enc   = wddl_encode(WDDL_MAX_W'(in_data));
  assign unused_enc = ^rail_enc;
  assign in_ready   = (state_q == IDLE);

  wddl_rail_check #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_rail_check (
    .p_rail  (dp_p_in),
    .n_rail  (dp_n_in),
    .comp_ok (comp_ok),
    .zero_ok (zero_ok)
  );

  always_comb begin
    state_d     = state_q;
    eval_cnt_d  = eval_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    dp_p_d      = dp_p_out;
    dp_n_d      = dp_n_out;
    precharge_d = precharge;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_err_d   = out_err;
    pre_err_d   = pre_err;

    // Result handshake runs independently of the rail sequencing below.
    if (out_valid && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        dp_p_d      = '0;
        dp_n_d      = '0;
        precharge_d = 1'b1;
        if (in_valid) begin
          dp_p_d      = rail_enc.p[IN_WIDTH-1:0];
          dp_n_d      = rail_enc.n[IN_WIDTH-1:0];
          precharge_d = 1'b0;
          eval_cnt_d  = EVAL_LOAD;
          state_d     = EVAL;
        end
      end
      EVAL: begin
        if (eval_cnt_q != '0) begin
          eval_cnt_d = eval_cnt_q - 1'b1;
        end else begin
          out_data_d  = dp_p_in;
          out_err_d   = ~comp_ok;
          out_valid_d = 1'b1;
          dp_p_d      = '0;
          dp_n_d      = '0;
          precharge_d = 1'b1;
          pre_cnt_d   = PRE_LOAD;
          state_d     = PRE;
        end
      end
      PRE: begin
        if (pre_cnt_q != '0) begin
          pre_cnt_d = pre_cnt_q - 1'b1;
        end else begin
          if (!zero_ok) pre_err_d = 1'b1;
          state_d = (!out_valid || out_ready) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      eval_cnt_q <= '0;
      pre_cnt_q  <= '0;
      dp_p_out   <= '0;
      dp_n_out   <= '0;
      precharge  <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      pre_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      eval_cnt_q <= eval_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      dp_p_out   <= dp_p_d;
      dp_n_out   <= dp_n_d;
      precharge  <= precharge_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_err    <= out_err_d;
      pre_err    <= pre_err_d;
    end
  end

endmodule

// File: tb/tb_wddl_eval_ctrl.sv
// Bench for wddl_eval_ctrl: cycle-level timeline model for the default
// configuration plus an in-order scoreboard for a streaming EVAL=3/PRE=2 instance.
module tb_wddl_eval_ctrl;

  localparam int E0 = 2;
  localparam int P0 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  // Default-parameter instance
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_ready, precharge, out_valid, out_err, pre_err;
  logic [7:0] dp_p_out, dp_n_out, dp_p_in, dp_n_in, out_data;
  int         fault_mode = 0;
  logic       rails_active;

  assign rails_active = |(dp_p_out | dp_n_out);
  assign dp_p_in = dp_p_out | ((fault_mode == 1 && rails_active) ? 8'h08 : 8'h00)
                            | ((fault_mode == 2) ? 8'h01 : 8'h00);
  assign dp_n_in = dp_n_out | ((fault_mode == 1 && rails_active) ? 8'h08 : 8'h00);

  wddl_eval_ctrl #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .EVAL_CYCLES(E0), .PRE_CYCLES(P0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .dp_p_out(dp_p_out), .dp_n_out(dp_n_out),
    .dp_p_in(dp_p_in), .dp_n_in(dp_n_in), .precharge(precharge),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .pre_err(pre_err)
  );

  // Streaming instance, identity datapath
  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [7:0] in_data1 = '0;
  logic       in_ready1, precharge1, out_valid1, out_err1, pre_err1;
  logic [7:0] dp_p_out1, dp_n_out1, out_data1;

  wddl_eval_ctrl #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .EVAL_CYCLES(3), .PRE_CYCLES(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .dp_p_out(dp_p_out1), .dp_n_out(dp_n_out1),
    .dp_p_in(dp_p_out1), .dp_n_in(dp_n_out1), .precharge(precharge1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_err(out_err1), .pre_err(pre_err1)
  );

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a transaction is just "edges elapsed since acceptance".
  bit         m_started = 0;
  bit         m_busy, m_hold, m_ov, m_oe, m_pe, m_pc, m_ov_prev;
  int         m_age;
  logic [7:0] m_p, m_n, m_od;

  always @(posedge clk) begin
    m_started = 1;
    if (!rst_n) begin
      m_busy = 0; m_hold = 0; m_age = 0; m_p = '0; m_n = '0; m_pc = 1;
      m_ov = 0; m_od = '0; m_oe = 0; m_pe = 0;
    end else begin
      m_ov_prev = m_ov;
      if (m_ov && out_ready) m_ov = 0;
      if (!m_busy && !m_hold) begin
        if (in_valid) begin
          m_busy = 1; m_age = 0; m_p = in_data; m_n = ~in_data; m_pc = 0;
        end
      end else if (m_hold) begin
        if (out_ready) m_hold = 0;
      end else begin
        m_age++;
        if (m_age == E0) begin
          m_od = dp_p_in;
          m_oe = ((dp_p_in ^ dp_n_in) != 8'hFF);
          m_ov = 1; m_p = '0; m_n = '0; m_pc = 1;
        end else if (m_age == E0 + P0) begin
          if ((dp_p_in | dp_n_in) != 8'h00) m_pe = 1;
          m_busy = 0;
          if (m_ov_prev && !out_ready) m_hold = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready",  in_ready,  (!m_busy && !m_hold));
      chk("dp_p_out",  dp_p_out,  m_p);
      chk("dp_n_out",  dp_n_out,  m_n);
      chk("precharge", precharge, m_pc);
      chk("out_valid", out_valid, m_ov);
      chk("out_data",  out_data,  m_od);
      chk("out_err",   out_err,   m_oe);
      chk("pre_err",   pre_err,   m_pe);
    end
  end

  // Returns at the first negedge after the accepting edge.
  task automatic send(input logic [7:0] d);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("accept_in_time", (g < 50), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [7:0] exp_q[$];
  int         got1 = 0;

  initial begin
    // Reset with a pending operand
    in_valid = 1'b1; in_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_dp_p", dp_p_out, 8'h00);
      chk("rst_precharge", precharge, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // Single transaction
    send(8'hA5);
    chk("t1_dp_p", dp_p_out, 8'hA5);
    chk("t1_dp_n", dp_n_out, 8'h5A);
    skip(1);
    chk("t2_dp_p", dp_p_out, 8'hA5);
    skip(1);
    chk("t3_out_valid", out_valid, 1'b1);
    chk("t3_out_data", out_data, 8'hA5);
    chk("t3_out_err", out_err, 1'b0);
    chk("t3_rails_zero", {dp_p_out, dp_n_out}, 16'h0000);
    skip(1);
    chk("t4_in_ready", in_ready, 1'b1);

    // Backpressure
    out_ready = 1'b0;
    send(8'h3C);
    skip(2);
    chk("bp_out_valid", out_valid, 1'b1);
    for (int i = 0; i < 6; i++) begin
      skip(1);
      chk("bp_hold_in_ready", in_ready, 1'b0);
      chk("bp_hold_data", out_data, 8'h3C);
    end
    out_ready = 1'b1;
    skip(1);
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_idle", in_ready, 1'b1);

    // Evaluate fault on bit 3
    fault_mode = 1;
    send(8'h96);
    skip(2);
    chk("ef_out_valid", out_valid, 1'b1);
    chk("ef_out_err", out_err, 1'b1);
    chk("ef_out_data", out_data, 8'h9E);
    skip(1);
    chk("ef_pre_err", pre_err, 1'b0);
    fault_mode = 0;

    // Precharge fault on bit 0, then a clean transaction
    fault_mode = 2;
    send(8'hC3);
    skip(2);
    chk("pf_out_err", out_err, 1'b0);
    skip(1);
    chk("pf_pre_err", pre_err, 1'b1);
    fault_mode = 0;
    send(8'h5A);
    skip(2);
    chk("pf2_out_data", out_data, 8'h5A);
    chk("pf2_sticky", pre_err, 1'b1);
    skip(2);
    rst_n = 1'b0;
    skip(1);
    chk("pf_rst_clear", pre_err, 1'b0);
    rst_n = 1'b1;
    skip(1);

    // Streaming on the EVAL=3/PRE=2 instance
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int g = 0;
          logic [7:0] d;
          d = 8'($urandom);
          in_data1  = d;
          in_valid1 = 1'b1;
          while (!in_ready1 && g < 50) begin
            @(negedge clk);
            g++;
          end
          chk("s_accept_in_time", (g < 50), 1);
          exp_q.push_back(d);
          @(negedge clk);
        end
        in_valid1 = 1'b0;
      end
      begin
        int last = -1;
        for (int k = 0; k < 120; k++) begin
          @(negedge clk);
          if (out_valid1) begin
            chk("s_have_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("s_out_data", out_data1, exp_q.pop_front());
            chk("s_out_err", out_err1, 1'b0);
            if (last >= 0) chk("s_interval", cyc - last, 6);
            last = cyc;
            got1++;
          end
        end
      end
    join
    chk("s_result_count", got1, 10);
    chk("s_pre_err", pre_err1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
